alu_mul_sequencer: RTL and testbench

Multi-cycle controller that drives the ALU's operand and command inputs and consumes its out/carryout results. It computes an unsigned 32x32 -> 64-bit product by shift-add, one ALU ADD per cycle. It sits between the datapath controller (start/done handshake) and a shared combinational ALU instance. The block owns the ALU inputs only while busy.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and the blocks that drive it.
//   - ALU command encodings (only ADD is issued by the multiply sequencer)
//   - ALU datapath width
//   - Multiply sequencer state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] XOR  = 3'd2;
  localparam logic [2:0] SLT  = 3'd3;
  localparam logic [2:0] AND  = 3'd4;
  localparam logic [2:0] NAND = 3'd5;
  localparam logic [2:0] NOR  = 3'd6;
  localparam logic [2:0] OR   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer
// Unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier that borrows an
// external combinational ALU, issuing one ADD per RUN cycle.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 request, sampled only in IDLE
//   op_a, op_b            multiplicand / multiplier, captured on accepted start
//   busy                  high while in RUN
//   done                  one-cycle pulse in DONE
//   product               result, held until the next completed operation
//   alu_a, alu_b, alu_cmd ALU inputs; driven only in RUN, zero/ADD otherwise
//   alu_out, alu_carryout ALU sum and 33rd sum bit, consumed the same cycle
//
// Configuration:
//   MUL_EARLY_TERM_EN     when defined, RUN stops as soon as the remaining
//                         multiplier bits are all zero and the partial product
//                         is right-aligned with a 64-bit logical shift.
// ---------------------------------------------------------------------------
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_cmd,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_carryout
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_t         state_r, state_nxt_s;
  logic [WIDTH-1:0]   m_r, m_nxt_s;
  logic [WIDTH-1:0]   p_hi_r, p_hi_nxt_s;
  logic [WIDTH-1:0]   p_lo_r, p_lo_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [2*WIDTH-1:0] product_r, product_nxt_s;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   alu_a_s, alu_b_s;
  logic [2:0]         alu_cmd_s;

  // Partial product after this cycle's add: {carry, sum, P_lo} shifted right by one.
  logic [WIDTH-1:0]   run_hi_s, run_lo_s;
  logic               run_last_s;
  logic [2*WIDTH-1:0] run_product_s;

  assign run_hi_s = {alu_carryout, alu_out[WIDTH-1:1]};
  assign run_lo_s = {alu_out[0], p_lo_r[WIDTH-1:1]};

`ifdef MUL_EARLY_TERM_EN
  // After cnt+1 iterations the unconsumed multiplier bits sit in
  // run_lo_s[WIDTH-2-cnt:0]; the product bits occupy everything above them.
  logic [WIDTH-1:0] live_mask_s;
  assign live_mask_s   = {WIDTH{1'b1}} >> (cnt_r + CNT_W'(1));
  assign run_last_s    = ((run_lo_s & live_mask_s) == {WIDTH{1'b0}});
  assign run_product_s = {run_hi_s, run_lo_s} >> (LAST_CNT - cnt_r);
`else
  assign run_last_s    = (cnt_r == LAST_CNT);
  assign run_product_s = {run_hi_s, run_lo_s};
`endif

  // Next-state, datapath update and ALU drive.
  always_comb begin
    state_nxt_s   = state_r;
    m_nxt_s       = m_r;
    p_hi_nxt_s    = p_hi_r;
    p_lo_nxt_s    = p_lo_r;
    cnt_nxt_s     = cnt_r;
    product_nxt_s = product_r;
    alu_a_s       = {WIDTH{1'b0}};
    alu_b_s       = {WIDTH{1'b0}};
    alu_cmd_s     = ADD;

    case (state_r)
      IDLE: begin
        if (start) begin
          m_nxt_s     = op_a;
          p_hi_nxt_s  = {WIDTH{1'b0}};
          p_lo_nxt_s  = op_b;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        alu_a_s    = p_hi_r;
        alu_b_s    = p_lo_r[0] ? m_r : {WIDTH{1'b0}};
        alu_cmd_s  = ADD;
        p_hi_nxt_s = run_hi_s;
        p_lo_nxt_s = run_lo_s;
        cnt_nxt_s  = cnt_r + CNT_W'(1);
        if (run_last_s) begin
          product_nxt_s = run_product_s;
          state_nxt_s   = DONE;
        end else begin
          state_nxt_s   = RUN;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, operand and result registers; busy/done track the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      m_r       <= {WIDTH{1'b0}};
      p_hi_r    <= {WIDTH{1'b0}};
      p_lo_r    <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      m_r       <= m_nxt_s;
      p_hi_r    <= p_hi_nxt_s;
      p_lo_r    <= p_lo_nxt_s;
      cnt_r     <= cnt_nxt_s;
      product_r <= product_nxt_s;
      busy_r    <= (state_nxt_s == RUN);
      done_r    <= (state_nxt_s == DONE);
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;
  assign alu_a   = alu_a_s;
  assign alu_b   = alu_b_s;
  assign alu_cmd = alu_cmd_s;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_sequencer
// Directed, table-driven bench for alu_mul_sequencer with a behavioural ADD
// ALU wired beside it. Expected cycle counts follow MUL_EARLY_TERM_EN.
// ---------------------------------------------------------------------------
module tb_alu_mul_sequencer;
  import alu_pkg::*;

`ifdef MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [63:0] product;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_cmd;
  logic        alu_carryout;
  logic [32:0] alu_sum;

  int checks;
  int failures;

  alu_mul_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_a         (op_a),
    .op_b         (op_b),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cmd      (alu_cmd),
    .alu_out      (alu_out),
    .alu_carryout (alu_carryout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: only ADD is modelled, other commands yield zero.
  always_comb begin
    alu_sum = 33'd0;
    if (alu_cmd == ADD) begin
      alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    end else begin
      alu_sum = 33'd0;
    end
  end
  assign alu_out      = alu_sum[31:0];
  assign alu_carryout = alu_sum[32];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int          cyc_et;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Waits (bounded) for done; counts busy cycles and the cycle index of done
  // relative to the accepting edge. Called at the negedge where start is driven.
  task automatic wait_done(input bit drop_start, input int change_at,
                           output int run, output int done_at, output int cmd_bad);
    run = 0; done_at = -1; cmd_bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1 && drop_start) start = 1'b0;
      if (k == change_at) begin
        op_a = 32'd9;
        op_b = 32'd9;
      end
      if (busy) begin
        run++;
        if (alu_cmd != ADD) cmd_bad++;
      end
      if (done) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input int idx);
    int run, done_at, cmd_bad, exp_cyc;
    exp_cyc = ET ? vecs[idx].cyc_et : 32;
    @(negedge clk);
    op_a  = vecs[idx].a;
    op_b  = vecs[idx].b;
    start = 1'b1;
    wait_done(1'b1, 0, run, done_at, cmd_bad);
    chk($sformatf("v%0d_run_cycles", idx), 64'(run), 64'(exp_cyc));
    chk($sformatf("v%0d_done_cycle", idx), 64'(done_at), 64'(exp_cyc + 1));
    chk($sformatf("v%0d_product", idx), product, vecs[idx].p);
    chk($sformatf("v%0d_cmd_add", idx), 64'(cmd_bad), 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), {62'd0, done, busy}, 64'd0);
    chk($sformatf("v%0d_idle_alu", idx), {alu_a, alu_b}, 64'd0);
    chk($sformatf("v%0d_product_hold", idx), product, vecs[idx].p);
  endtask

  initial begin
    int run, done_at, cmd_bad;
    checks   = 0;
    failures = 0;

    vecs[0] = '{32'd3,         32'd5,         64'd15,                  3};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001,  32};
    vecs[2] = '{32'h12345678,  32'd0,         64'd0,                   1};
    vecs[3] = '{32'd7,         32'd2,         64'd14,                  2};
    vecs[4] = '{32'd7,         32'h80000000,  64'h00000003_80000000,  32};
    vecs[5] = '{32'h0000FFFF,  32'h00010000,  64'h00000000_FFFF0000,  17};
    vecs[6] = '{32'd6,         32'd7,         64'd42,                  3};
    vecs[7] = '{32'h80000000,  32'd2,         64'h00000001_00000000,   2};

    reset = 1'b1;
    start = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    chk("reset_product", product, 64'd0);
    chk("reset_alu_ab", {alu_a, alu_b}, 64'd0);
    chk("reset_alu_cmd", 64'(alu_cmd), 64'(ADD));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start", {62'd0, busy, done}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(i);
    end

    // start held high with operands changing mid-RUN.
    @(negedge clk);
    op_a  = 32'd3;
    op_b  = 32'd5;
    start = 1'b1;
    wait_done(1'b0, 2, run, done_at, cmd_bad);
    chk("held_done_cycle", 64'(done_at), 64'(ET ? 4 : 33));
    chk("held_product", product, 64'd15);
    @(negedge clk);
    chk("held_idle_gap", {62'd0, busy, done}, 64'd0);
    wait_done(1'b1, 0, run, done_at, cmd_bad);
    chk("held_second_cycles", 64'(run), 64'(ET ? 4 : 32));
    chk("held_second_product", product, 64'd81);

    // Reset during RUN cycle 10.
    @(negedge clk);
    op_a  = 32'hFFFF;
    op_b  = 32'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy_done", {62'd0, busy, done}, 64'd0);
    chk("midrun_reset_product", product, 64'd0);
    chk("midrun_reset_alu", {alu_a, alu_b}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    vecs[0] = '{32'd7, 32'd6, 64'd42, 3};
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
